vga_sync_tracker: RTL
=====================

# vga_sync_tracker

Receive-side counterpart of the VGA timing generator. It takes hsync/vsync sampled on the pixel clock and recovers the horizontal and vertical position of every sample. It checks the sync stream against the 640x480@60 timing, which is 800 clocks per line and 525 lines per frame, and reports lock and sync errors. It sits on the capture/loopback path and in testbenches, directly downstream of the sync pins.

## Interface
- H_TOTAL, 800: clocks per line
- H_ACTIVE, 640: visible clocks per line
- H_SYNC_START, 656: hpos of the first hsync-low sample
- H_SYNC_END, 752: hpos of the first hsync-high sample after the pulse
- V_TOTAL, 525: lines per frame
- V_ACTIVE, 480: visible lines
- V_SYNC_START, 490: vpos of the first vsync-low line
- V_SYNC_END, 492: vpos of the first vsync-high line after the pulse
- LOCK_FRAMES, 2: error-free frames required in VERIFY before LOCKED
- clk, input, 1: pixel clock
- nRst, input, 1: reset, asynchronous, active-low
- hsync_in, input, 1: active-low hsync, synchronous to clk
- vsync_in, input, 1: active-low vsync, synchronous to clk
- hpos, output, 10: recovered horizontal position of the current sample
- vpos, output, 10: recovered vertical position of the current sample
- active, output, 1: current sample is visible and the tracker is locked
- locked, output, 1: tracker is in LOCKED
- frame_start, output, 1: one-cycle pulse at (0,0) while locked
- sync_err, output, 1: one-cycle pulse on a sync mismatch in VERIFY or LOCKED

## Operation
- **Edge detection**
  - hs_q and vs_q hold the previous-cycle sync levels; both reset to 1.
  - hfall = hs_q & !hsync_in; vfall = vs_q & !vsync_in.
- **Counters**
  - hcnt wraps H_TOTAL-1 -> 0. On each wrap, vcnt increments and wraps V_TOTAL-1 -> 0.
  - hpos = hcnt and vpos = vcnt, both combinational from the registers.
- **Expected levels**
  - exp_hs is low iff H_SYNC_START <= hcnt < H_SYNC_END.
  - exp_vs is low iff V_SYNC_START <= vcnt < V_SYNC_END.
- **FSM, SEARCH** (reset state)
  - On hfall: hcnt <= H_SYNC_START+1 and set h_aligned.
  - On vfall with h_aligned: vcnt <= V_SYNC_START, good <= 0, go to VERIFY.
  - On vfall without h_aligned: ignored.
  - No error checking in this state.
- **FSM, VERIFY**
  - Counters free-run with no reload.
  - Every cycle: if hsync_in != exp_hs or vsync_in != exp_vs, pulse sync_err, clear h_aligned, go to SEARCH.
  - On an error-free vfall, good increments. When good reaches LOCK_FRAMES, go to LOCKED.
- **FSM, LOCKED**
  - Same per-cycle checks as VERIFY.
  - A mismatch pulses sync_err, drops locked and goes to SEARCH. The counters keep running.
- **Status outputs**
  - active = locked & (hcnt < H_ACTIVE) & (vcnt < V_ACTIVE).
  - frame_start = locked & hcnt==0 & vcnt==0.
- **Width rules**
  - All compares are unsigned 10-bit.
  - The good counter is wide enough for LOCK_FRAMES and saturates.

## Timing
- **Reset values**
  - hcnt, vcnt, hpos, vpos: 0.
  - active, locked, frame_start, sync_err: 0.
  - hs_q, vs_q: 1. State: SEARCH. h_aligned: 0.
- **Sample alignment**
  - In the cycle where hfall is seen, the sample is hpos 656.
  - In the next cycle the register holds 657, so outputs line up with the current input sample with zero latency.
- **vsync edge position**
  - The generator drops vsync at hpos 0 of line 490.
  - A vfall in VERIFY or LOCKED at any other (hcnt, vcnt) is a mismatch, because the level check fails in that same cycle.
- **Lock time from a clean stream**
  - SEARCH exits at the first vfall after an hfall.
  - The tracker enters LOCKED in the cycle after the LOCK_FRAMES-th subsequent vfall. With defaults that is 2x420000 clocks.
  - locked rises in the cycle after that vfall.
- **Mismatch timing**
  - The mismatch cycle itself shows sync_err=1.
  - locked and active are 0 from the next cycle onward.
- **Simultaneous events**
  - hfall and vfall together in SEARCH: both reloads apply in the same cycle. h_aligned must already be set from an earlier hfall for the transition.
  - A mismatch on the same cycle as the LOCK_FRAMES-th vfall: the error wins and the FSM goes to SEARCH.
- **Asynchronous reset mid-frame** returns every output and register to its reset value immediately. Re-lock follows the full lock sequence.

## Structure
- **vga_timing_pkg** holds all of the following; both the generator and the tracker use it:
  - the H_* and V_* default constants
  - the FSM state encoding (SEARCH, VERIFY, LOCKED)
  - a shared exp-level helper function
- **Sub-module vga_sync_edge**: one instance per sync line. It contains the registered previous level and outputs the fall pulse.

## Test plan
- Generator instance drives the tracker from reset.
  - Expect: locked=0 until the 3rd vfall after the first hfall, then 1.
  - Once locked, hpos and vpos equal the generator counters every cycle.
- Locked stream, force hsync_in high for one cycle at hpos 700.
  - Expect: sync_err pulses at that cycle, locked=0 from the next cycle.
  - Re-lock occurs after 2 further clean frames.
- Locked stream, insert one extra clock into a single line (line length 801).
  - Expect: sync_err at the next hsync fall or rise mismatch, then return to SEARCH.
- vsync dropped at (0,491) instead of (0,490).
  - Expect: no lock, sync_err in VERIFY, FSM stays out of LOCKED.
- nRst asserted at (300,200) while locked.
  - Expect: all outputs 0 immediately. After release, re-lock takes the full lock sequence again.
- Locked stream, check the status outputs.
  - Expect: frame_start is one cycle at (0,0).
  - active=1 at (639,479); active=0 at (640,0) and at (0,480).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, tracker state encoding and the expected
// sync-level helper used by both the VGA generator and the sync tracker.
package vga_timing_pkg;

    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam int unsigned LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } trk_state_e;

    // Active-low sync: low inside [start, stop), high elsewhere.
    function automatic logic sync_level_exp(
        input logic [9:0] cnt,
        input logic [9:0] start,
        input logic [9:0] stop
    );
        return !((cnt >= start) && (cnt < stop));
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Falling-edge detector for one active-low sync line; the previous level
// resets high so a line held low through reset does not fake an edge.
module vga_sync_edge (
    input  logic clk,
    input  logic nRst,
    input  logic sync_i,
    output logic fall_o
);

    logic level_q;

    // Previous-cycle sync level.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= sync_i;
        end
    end

    assign fall_o = level_q & ~sync_i;

endmodule

// File: rtl/vga_sync_tracker.sv
// Recovers (hpos, vpos) from sampled hsync/vsync, verifies the stream against
// the configured VGA timing and reports lock and per-cycle sync errors.
module vga_sync_tracker #(
    parameter logic [9:0]  H_TOTAL      = vga_timing_pkg::H_TOTAL,
    parameter logic [9:0]  H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
    parameter logic [9:0]  H_SYNC_START = vga_timing_pkg::H_SYNC_START,
    parameter logic [9:0]  H_SYNC_END   = vga_timing_pkg::H_SYNC_END,
    parameter logic [9:0]  V_TOTAL      = vga_timing_pkg::V_TOTAL,
    parameter logic [9:0]  V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
    parameter logic [9:0]  V_SYNC_START = vga_timing_pkg::V_SYNC_START,
    parameter logic [9:0]  V_SYNC_END   = vga_timing_pkg::V_SYNC_END,
    parameter int unsigned LOCK_FRAMES  = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       active,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
);

    import vga_timing_pkg::*;

    localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 2);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_FRAMES);

    logic [9:0]        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0]        hcnt_inc_s, vcnt_inc_s;
    trk_state_e        state_q, state_d;
    logic              h_aligned_q, h_aligned_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc_s;
    logic              hfall_s, vfall_s, mismatch_s, h_wrap_s;

    vga_sync_edge u_hs_edge (
        .clk    (clk),
        .nRst   (nRst),
        .sync_i (hsync_in),
        .fall_o (hfall_s)
    );

    vga_sync_edge u_vs_edge (
        .clk    (clk),
        .nRst   (nRst),
        .sync_i (vsync_in),
        .fall_o (vfall_s)
    );

    assign h_wrap_s   = (hcnt_q == (H_TOTAL - 10'd1));
    assign hcnt_inc_s = h_wrap_s ? 10'd0 : (hcnt_q + 10'd1);
    assign vcnt_inc_s = !h_wrap_s ? vcnt_q :
                        ((vcnt_q == (V_TOTAL - 10'd1)) ? 10'd0 : (vcnt_q + 10'd1));
    assign good_inc_s = (good_q >= GOOD_LOCK) ? GOOD_LOCK : (good_q + GOOD_W'(1));

    // Level check is against the counters for this very sample, so a
    // misplaced edge is caught in the cycle it arrives.
    assign mismatch_s = (hsync_in != sync_level_exp(hcnt_q, H_SYNC_START, H_SYNC_END)) ||
                        (vsync_in != sync_level_exp(vcnt_q, V_SYNC_START, V_SYNC_END));

    // Next-state: counter reloads in SEARCH, error/lock tracking otherwise.
    always_comb begin
        hcnt_d      = hcnt_inc_s;
        vcnt_d      = vcnt_inc_s;
        state_d     = state_q;
        h_aligned_d = h_aligned_q;
        good_d      = good_q;
        case (state_q)
            SEARCH: begin
                // Reload to the sample after the one carrying the edge.
                if (hfall_s) begin
                    hcnt_d      = H_SYNC_START + 10'd1;
                    h_aligned_d = 1'b1;
                end else begin
                    hcnt_d      = hcnt_inc_s;
                    h_aligned_d = h_aligned_q;
                end
                if (vfall_s && h_aligned_q) begin
                    vcnt_d  = V_SYNC_START;
                    good_d  = '0;
                    state_d = VERIFY;
                end else begin
                    vcnt_d  = vcnt_inc_s;
                    good_d  = good_q;
                    state_d = SEARCH;
                end
            end
            VERIFY, LOCKED: begin
                if (mismatch_s) begin
                    state_d     = SEARCH;
                    h_aligned_d = 1'b0;
                end else if (vfall_s && (state_q == VERIFY)) begin
                    good_d  = good_inc_s;
                    state_d = (good_inc_s >= GOOD_LOCK) ? LOCKED : VERIFY;
                end else begin
                    good_d  = good_q;
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = SEARCH;
                h_aligned_d = 1'b0;
                good_d      = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hcnt_q      <= 10'd0;
            vcnt_q      <= 10'd0;
            state_q     <= SEARCH;
            h_aligned_q <= 1'b0;
            good_q      <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            state_q     <= state_d;
            h_aligned_q <= h_aligned_d;
            good_q      <= good_d;
        end
    end

    assign hpos        = hcnt_q;
    assign vpos        = vcnt_q;
    assign locked      = (state_q == LOCKED);
    assign active      = locked & (hcnt_q < H_ACTIVE) & (vcnt_q < V_ACTIVE);
    assign frame_start = locked & (hcnt_q == 10'd0) & (vcnt_q == 10'd0);
    assign sync_err    = (state_q != SEARCH) & mismatch_s;

endmodule
